// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory load/store path: funct3 widths,
// access FSM states, fault codes and alignment helpers.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } mem_state_e;

    // Reserved encodings (011/110/111) fall through to a word access.
    function automatic logic [1:0] acc_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: acc_size = SZ_BYTE;
            F3_H, F3_HU: acc_size = SZ_HALF;
            default:     acc_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: is_aligned = 1'b1;
            SZ_HALF: is_aligned = ~off[0];
            default: is_aligned = (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a bus read word and sign- or
// zero-extends it according to funct3.
module load_extend
    import rv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    output logic [31:0] extended
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{byte_off, 3'b000} +: 8];
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    extended = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   extended = {24'h0, byte_sel};
            F3_H:    extended = {{16{half_sel[15]}}, half_sel};
            F3_HU:   extended = {16'h0, half_sel};
            default: extended = rdata;
        endcase
    end

endmodule

// File: rtl/data_mem_access.sv
// Load/store unit: runs one req/ack transaction per memory instruction,
// stalls the core meanwhile and returns extended load data to writeback.
module data_mem_access
    import rv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    mem_state_e       state_q, state_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic             bus_we_q, bus_we_d;
    logic [3:0]       bus_be_q, bus_be_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [31:0]      load_data_q, load_data_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;

    logic             access;
    logic             aligned;
    logic             mis_fault;
    logic             timeout_hit;
    logic [1:0]       size;
    logic [3:0]       req_be;
    logic [31:0]      req_wdata;
    logic [31:0]      ext_data;
    logic [CNT_W-1:0] cnt_inc;

    load_extend u_load_extend (
        .rdata    (bus_rdata),
        .funct3   (f3_q),
        .byte_off (off_q),
        .extended (ext_data)
    );

    // Request decode: lane enables and replicated write data for this access.
    always_comb begin
        access    = mem_read | mem_write;
        size      = acc_size(funct3);
        aligned   = is_aligned(size, addr[1:0]);
        req_be    = 4'b1111;
        req_wdata = store_data;
        if (mem_write) begin
            case (size)
                SZ_BYTE: begin
                    req_be    = 4'b0001 << addr[1:0];
                    req_wdata = {4{store_data[7:0]}};
                end
                SZ_HALF: begin
                    req_be    = addr[1] ? 4'b1100 : 4'b0011;
                    req_wdata = {2{store_data[15:0]}};
                end
                default: ;
            endcase
        end
        cnt_inc     = cnt_q + CNT_W'(1);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIMIT);
    end

    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        load_data_d = load_data_q;
        f3_d        = f3_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        fault_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access && aligned) begin
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_we_d    = mem_write;
                    bus_be_d    = req_be;
                    bus_wdata_d = req_wdata;
                    f3_d        = funct3;
                    off_d       = addr[1:0];
                    cnt_d       = '0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // An ack arriving on the last allowed cycle still wins over the timeout.
                if (bus_ack) begin
                    if (!bus_we_q) load_data_d = ext_data;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    if (!bus_we_q) load_data_d = '0;
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            load_data_q <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            load_data_q <= load_data_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            fault_q     <= fault_d;
        end
    end

    // Misalignment is reported in the request cycle; timeout comes from fault_q in DONE.
    always_comb begin
        mis_fault  = (state_q == ST_IDLE) && access && !aligned;
        stall      = ((state_q == ST_IDLE) && access && aligned) || (state_q == ST_BUSY);
        bus_req    = (state_q == ST_BUSY);
        fault      = mis_fault | fault_q;
        fault_code = mis_fault ? FAULT_MISALIGN : (fault_q ? FAULT_TIMEOUT : FAULT_NONE);
    end

    assign load_data = load_data_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Scoreboard bench for data_mem_access: expected load_data is queued at
// request time and compared when the access completes.
module tb_data_mem_access;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        stall, fault;
    logic [1:0]  fault_code;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ack;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_ld = 32'h0;

    data_mem_access #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .load_data(load_data), .stall(stall), .fault(fault), .fault_code(fault_code),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] rd,
                                              input logic [1:0] off);
        logic [31:0] sh;
        sh = rd >> (8 * off);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    // ack_at = BUSY cycle number carrying bus_ack; 0 means never ack (timeout).
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int ack_at, input logic [31:0] rdata, input string tag);
        logic [1:0]  off, sz;
        logic        mis, timed_out, done;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_ld;
        int          exp_busy, busy, stalls;
        off       = a[1:0];
        sz        = f3[1:0];
        mis       = (sz == 2'b01 && off[0]) || (sz[1] && off != 2'b00);
        timed_out = (ack_at == 0);
        exp_busy  = timed_out ? TO : ack_at;
        exp_be    = 4'b1111;
        exp_wd    = sd;
        if (wr) begin
            if (sz == 2'b00) begin exp_be = 4'b0001 << off; exp_wd = {4{sd[7:0]}}; end
            else if (sz == 2'b01) begin exp_be = off[1] ? 4'b1100 : 4'b0011; exp_wd = {2{sd[15:0]}}; end
        end

        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd; bus_ack = 1'b0;
        @(negedge clk);
        check({tag, ".req_stall"}, 32'(stall), 32'(!mis));
        check({tag, ".req_fault"}, 32'(fault), 32'(mis));
        if (mis) begin
            check({tag, ".req_code"}, 32'(fault_code), 32'h1);
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0;
            @(negedge clk);
            check({tag, ".mis_no_req"}, 32'(bus_req), 32'h0);
            check({tag, ".mis_fault_gone"}, 32'(fault), 32'h0);
            return;
        end

        if (!wr) model_ld = timed_out ? 32'h0 : ext_model(f3, rdata, off);
        exp_q.push_back(model_ld);

        busy = 0; stalls = 1; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk); #1;
            if (bus_req) begin
                busy++;
                bus_ack   = (busy == ack_at);
                bus_rdata = bus_ack ? rdata : 32'hDEAD_BEEF;
                if (busy == 1 || busy == exp_busy) begin
                    check({tag, ".bus_addr"}, bus_addr, {a[31:2], 2'b00});
                    check({tag, ".bus_we"}, 32'(bus_we), 32'(wr));
                    check({tag, ".bus_be"}, 32'(bus_be), 32'(exp_be));
                    if (wr) check({tag, ".bus_wdata"}, bus_wdata, exp_wd);
                end
                @(negedge clk);
                if (stall) stalls++;
            end else begin
                // Stray ack in DONE must have no effect.
                bus_ack   = 1'b1;
                bus_rdata = 32'h1357_9BDF;
                @(negedge clk);
                check({tag, ".done_stall"}, 32'(stall), 32'h0);
                check({tag, ".done_fault"}, 32'(fault), 32'(timed_out));
                check({tag, ".done_code"}, 32'(fault_code), timed_out ? 32'h2 : 32'h0);
                exp_ld = exp_q.pop_front();
                check({tag, ".load_data"}, load_data, exp_ld);
                done = 1'b1;
            end
        end
        if (!done) check({tag, ".completed"}, 32'h0, 32'h1);
        check({tag, ".busy_cycles"}, 32'(busy), 32'(exp_busy));
        check({tag, ".stall_cycles"}, 32'(stalls), 32'(exp_busy + 1));
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h2468_ACE0;
        @(negedge clk);
        check({tag, ".bus_req"}, 32'(bus_req), 32'h0);
        check({tag, ".stall"}, 32'(stall), 32'h0);
        check({tag, ".load_data"}, load_data, model_ld);
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = '0; store_data = '0; bus_rdata = '0; bus_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst.load_data", load_data, 32'h0);
        check("rst.bus_req", 32'(bus_req), 32'h0);
        check("rst.bus_we", 32'(bus_we), 32'h0);
        check("rst.bus_addr", bus_addr, 32'h0);
        check("rst.bus_be", 32'(bus_be), 32'h0);
        check("rst.bus_wdata", bus_wdata, 32'h0);
        check("rst.fault", 32'(fault), 32'h0);
        check("rst.fault_code", 32'(fault_code), 32'h0);
        check("rst.stall", 32'(stall), 32'h0);

        access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,         2, 32'h80FF_1234, "lb");
        access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 1, 32'h0,         "sh");
        access(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0,         1, 32'h0,         "lw_mis");
        access(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0,         0, 32'h0,         "lw_to");
        access(1'b1, 1'b0, 3'b101, 32'h0000_5002, 32'h0,         1, 32'h8001_0000, "lhu");
        access(1'b1, 1'b0, 3'b001, 32'h0000_5002, 32'h0,         1, 32'h8001_0000, "lh");
        access(1'b1, 1'b1, 3'b000, 32'h0000_6001, 32'h0000_00A5, 2, 32'h0,         "rw_sb");
        access(1'b1, 1'b0, 3'b100, 32'h0000_6003, 32'h0,         1, 32'hC300_0000, "lbu");
        access(1'b1, 1'b0, 3'b011, 32'h0000_6004, 32'h0,         3, 32'h1234_5678, "lw_f3_011");
        access(1'b1, 1'b0, 3'b001, 32'h0000_5001, 32'h0,         1, 32'h0,         "lh_mis");
        access(1'b0, 1'b1, 3'b010, 32'h0000_8000, 32'hA1B2_C3D4, 0, 32'h0,         "sw_to");
        access(1'b1, 1'b0, 3'b001, 32'h0000_9000, 32'h0,         1, 32'h0000_F00D, "lh_pre_rst");
        idle_check("idle");

        // Reset lands in the second BUSY cycle; the ack that follows must be ignored.
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_7000; bus_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_rst.busy", 32'(bus_req), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("mid_rst.bus_req", 32'(bus_req), 32'h0);
        check("mid_rst.stall", 32'(stall), 32'h0);
        check("mid_rst.load_data", load_data, 32'h0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check("mid_rst.late_ack_req", 32'(bus_req), 32'h0);
        check("mid_rst.late_ack_ld", load_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
